// File: rtl/mips_cpu_bus.sv
// Multicycle MIPS-I subset CPU on an Avalon-style memory bus.
// One instruction walks FETCH -> EXEC -> (MEM) -> WB. A single
// shared bus serves both instruction fetch and LW/SW. A pc/npc pair
// provides the one-instruction branch delay slot. The CPU halts when the
// next fetch would be from address 0.
module mips_cpu_bus #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        active,
    output logic [31:0] register_v0,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic        write,
    output logic        read,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    output logic [31:0] address
);

    typedef enum logic [2:0] {FETCH, EXEC, MEM, WB, HALTED} state_t;

    localparam logic [5:0] OP_SPECIAL = 6'h00, OP_J     = 6'h02, OP_JAL   = 6'h03,
                           OP_BEQ     = 6'h04, OP_BNE   = 6'h05, OP_ADDIU = 6'h09,
                           OP_SLTI    = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI  = 6'h0C,
                           OP_ORI     = 6'h0D, OP_XORI  = 6'h0E, OP_LUI   = 6'h0F,
                           OP_LW      = 6'h23, OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03,
                           FN_SLLV = 6'h04, FN_SRLV = 6'h06, FN_SRAV = 6'h07,
                           FN_JR   = 6'h08, FN_JALR = 6'h09, FN_ADDU = 6'h21,
                           FN_SUBU = 6'h23, FN_AND  = 6'h24, FN_OR   = 6'h25,
                           FN_XOR  = 6'h26, FN_SLT  = 6'h2A, FN_SLTU = 6'h2B;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;          // address of the instruction in flight / next to fetch
    logic [31:0] npc_q, npc_d;        // address of the instruction after pc (delay-slot successor)
    logic [31:0] ir_q, ir_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  wreg_q, wreg_d;      // 0 means no register writeback
    logic        active_q, active_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic [31:0] address_q, address_d;
    logic [31:0] writedata_q, writedata_d;
    logic [31:0] gpr_q [32];
    logic [31:0] gpr_d [32];

    // Instruction fields and operands
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] a, b, simm, zimm, pc4, pc8, br_tgt, j_tgt, ea;

    assign op     = ir_q[31:26];
    assign rs     = ir_q[25:21];
    assign rt     = ir_q[20:16];
    assign rd     = ir_q[15:11];
    assign shamt  = ir_q[10:6];
    assign funct  = ir_q[5:0];
    assign imm16  = ir_q[15:0];
    assign imm26  = ir_q[25:0];
    assign a      = gpr_q[rs];
    assign b      = gpr_q[rt];
    assign simm   = {{16{imm16[15]}}, imm16};
    assign zimm   = {16'h0000, imm16};
    assign pc4    = pc_q + 32'd4;
    assign pc8    = pc_q + 32'd8;
    assign br_tgt = pc4 + {simm[29:0], 2'b00};
    assign j_tgt  = {pc4[31:28], imm26, 2'b00};
    assign ea     = a + simm;

    assign active      = active_q;
    assign read        = read_q;
    assign write       = write_q;
    assign address     = address_q;
    assign writedata   = writedata_q;
    assign byteenable  = 4'b1111;
    assign register_v0 = gpr_q[2];

    // Next-state logic for the FSM, bus request registers and register file
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        npc_d       = npc_q;
        ir_d        = ir_q;
        result_d    = result_q;
        wreg_d      = wreg_q;
        active_d    = active_q;
        read_d      = read_q;
        write_d     = write_q;
        address_d   = address_q;
        writedata_d = writedata_q;
        gpr_d       = gpr_q;

        case (state_q)
            FETCH: begin
                if (!read_q) begin
                    // Only reached straight out of reset: raise the first fetch.
                    active_d  = 1'b1;
                    read_d    = 1'b1;
                    address_d = pc_q;
                end else if (!waitrequest) begin
                    ir_d    = readdata;
                    read_d  = 1'b0;
                    state_d = EXEC;
                end
            end

            EXEC: begin
                wreg_d   = 5'd0;
                result_d = 32'd0;
                pc_d     = npc_q;
                npc_d    = npc_q + 32'd4;
                state_d  = WB;
                case (op)
                    OP_SPECIAL: begin
                        wreg_d = rd;
                        case (funct)
                            FN_SLL:  result_d = b << shamt;
                            FN_SRL:  result_d = b >> shamt;
                            FN_SRA:  result_d = $signed(b) >>> shamt;
                            FN_SLLV: result_d = b << a[4:0];
                            FN_SRLV: result_d = b >> a[4:0];
                            FN_SRAV: result_d = $signed(b) >>> a[4:0];
                            FN_ADDU: result_d = a + b;
                            FN_SUBU: result_d = a - b;
                            FN_AND:  result_d = a & b;
                            FN_OR:   result_d = a | b;
                            FN_XOR:  result_d = a ^ b;
                            FN_SLT:  result_d = {31'd0, $signed(a) < $signed(b)};
                            FN_SLTU: result_d = {31'd0, a < b};
                            FN_JR: begin
                                wreg_d = 5'd0;
                                npc_d  = a;
                            end
                            FN_JALR: begin
                                npc_d    = a;
                                result_d = pc8;
                            end
                            default: wreg_d = 5'd0;
                        endcase
                    end
                    OP_J:   npc_d = j_tgt;
                    OP_JAL: begin
                        npc_d    = j_tgt;
                        result_d = pc8;
                        wreg_d   = 5'd31;
                    end
                    OP_BEQ: if (a == b) npc_d = br_tgt;
                    OP_BNE: if (a != b) npc_d = br_tgt;
                    OP_ADDIU: begin result_d = a + simm;                               wreg_d = rt; end
                    OP_SLTI:  begin result_d = {31'd0, $signed(a) < $signed(simm)};    wreg_d = rt; end
                    OP_SLTIU: begin result_d = {31'd0, a < simm};                      wreg_d = rt; end
                    OP_ANDI:  begin result_d = a & zimm;                               wreg_d = rt; end
                    OP_ORI:   begin result_d = a | zimm;                               wreg_d = rt; end
                    OP_XORI:  begin result_d = a ^ zimm;                               wreg_d = rt; end
                    OP_LUI:   begin result_d = {imm16, 16'h0000};                      wreg_d = rt; end
                    OP_LW: begin
                        wreg_d    = rt;
                        address_d = ea & ~32'd3;
                        read_d    = 1'b1;
                        state_d   = MEM;
                    end
                    OP_SW: begin
                        address_d   = ea & ~32'd3;
                        writedata_d = b;
                        write_d     = 1'b1;
                        state_d     = MEM;
                    end
                    default: ;  // unsupported opcodes retire as NOP
                endcase
            end

            MEM: begin
                // Request stays frozen until the slave drops waitrequest.
                if (!waitrequest) begin
                    if (read_q) result_d = readdata;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    state_d = WB;
                end
            end

            WB: begin
                if (wreg_q != 5'd0) gpr_d[wreg_q] = result_q;
                // A jump to 0 halts once its delay slot has retired.
                if (pc_q == 32'd0) begin
                    state_d  = HALTED;
                    active_d = 1'b0;
                end else begin
                    state_d   = FETCH;
                    read_d    = 1'b1;
                    address_d = pc_q;
                end
            end

            default: ;  // HALTED: bus idle until reset
        endcase
    end

    // State registers; reset aborts any in-progress access immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= FETCH;
            pc_q        <= RESET_VECTOR;
            npc_q       <= RESET_VECTOR + 32'd4;
            ir_q        <= 32'd0;
            result_q    <= 32'd0;
            wreg_q      <= 5'd0;
            active_q    <= 1'b0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            address_q   <= RESET_VECTOR;
            writedata_q <= 32'd0;
            for (int i = 0; i < 32; i++) gpr_q[i] <= 32'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            npc_q       <= npc_d;
            ir_q        <= ir_d;
            result_q    <= result_d;
            wreg_q      <= wreg_d;
            active_q    <= active_d;
            read_q      <= read_d;
            write_q     <= write_d;
            address_q   <= address_d;
            writedata_q <= writedata_d;
            for (int i = 0; i < 32; i++) gpr_q[i] <= gpr_d[i];
        end
    end

endmodule

// File: tb/tb_mips_cpu_bus.sv
// Bench for mips_cpu_bus: a word memory model with programmable wait
// states, a table of small programs with hand-computed results, and
// directed sequences for reset and a reset during a stalled fetch.
module tb_mips_cpu_bus;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        active;
    logic [31:0] register_v0;
    logic        waitrequest = 1'b0;
    logic [31:0] readdata = 32'd0;
    logic        write;
    logic        read;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic [31:0] address;

    mips_cpu_bus dut (
        .clk(clk), .reset(reset), .active(active), .register_v0(register_v0),
        .waitrequest(waitrequest), .readdata(readdata), .write(write), .read(read),
        .byteenable(byteenable), .writedata(writedata), .address(address)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [128];
    int          rd_wait = 0, wr_wait = 0, wcnt = 0;
    bit          force_wait = 1'b0;
    bit          prev_wait = 1'b0;
    logic        snap_rd, snap_wr;
    logic [31:0] snap_addr, snap_wdata;
    int          viol = 0, nwrites = 0;
    logic [31:0] waddr = 32'd0, wdata = 32'd0, first_raddr = 32'd0;
    bit          seen_read = 1'b0;
    int          napplied = 0, nmiss = 0;

    // Memory slave + protocol monitor, acting on the falling edge
    always @(negedge clk) begin
        logic [31:0] off;
        int          idx;
        if (reset) begin
            waitrequest = 1'b0;
            wcnt        = 0;
            prev_wait   = 1'b0;
        end else begin
            if (read && write) viol++;
            if ((read || write) && address[1:0] != 2'b00) viol++;
            if (prev_wait && (read !== snap_rd || write !== snap_wr ||
                address !== snap_addr || writedata !== snap_wdata || byteenable !== 4'hF)) viol++;
            if (read || write) begin
                if (address < 32'hBFC00000 || address >= 32'hBFC00200) viol++;
                if (read && !seen_read) begin
                    first_raddr = address;
                    seen_read   = 1'b1;
                end
                off = address - 32'hBFC00000;
                idx = int'(off[8:2]);
                if (force_wait || wcnt < (read ? rd_wait : wr_wait)) begin
                    waitrequest = 1'b1;
                    wcnt++;
                end else begin
                    waitrequest = 1'b0;
                    wcnt        = 0;
                    if (read) readdata = mem[idx];
                    else begin
                        mem[idx] = writedata;
                        nwrites++;
                        waddr = address;
                        wdata = writedata;
                    end
                end
            end else begin
                waitrequest = 1'b0;
                wcnt        = 0;
            end
            prev_wait  = waitrequest;
            snap_rd    = read;
            snap_wr    = write;
            snap_addr  = address;
            snap_wdata = writedata;
        end
    end

    function automatic logic [31:0] ei(int op, int rs, int rt, int imm);
        logic [31:0] o, s, t, m;
        o = op; s = rs; t = rt; m = imm;
        return {o[5:0], s[4:0], t[4:0], m[15:0]};
    endfunction

    function automatic logic [31:0] er(int rs, int rt, int rd, int sh, int fn);
        logic [31:0] s, t, d, h, f;
        s = rs; t = rt; d = rd; h = sh; f = fn;
        return {6'd0, s[4:0], t[4:0], d[4:0], h[4:0], f[5:0]};
    endfunction

    // J/JAL to word index w of the program area
    function automatic logic [31:0] ej(int op, int w);
        logic [31:0] o, ta;
        o  = op;
        ta = 32'hBFC00000 + 32'(w * 4);
        return {o[5:0], ta[27:2]};
    endfunction

    localparam logic [31:0] JR0 = 32'h00000008;

    task automatic load_prog(input int p);
        for (int i = 0; i < 128; i++) mem[i] = 32'd0;
        case (p)
            1: begin mem[0] = ei(9, 0, 2, 5); mem[1] = JR0; end
            2: begin
                mem[0] = ei('hF, 0, 3, 'hBFC0);  mem[1] = ei('hD, 0, 4, 'h1234);
                mem[2] = ei('h2B, 3, 4, 'h100);  mem[3] = ei('h23, 3, 2, 'h100);
                mem[4] = JR0;
            end
            3: begin
                mem[0] = ei(4, 0, 0, 2);  mem[1] = ei(9, 2, 2, 1);
                mem[2] = ei(9, 2, 2, 16); mem[3] = JR0;
            end
            4: begin mem[0] = ei(9, 0, 5, 'hFFFD); mem[1] = er(0, 5, 2, 1, 3); mem[2] = JR0; end
            5: begin
                mem[0] = ei(9, 0, 5, 'hFFFF);    mem[1] = er(5, 0, 6, 0, 'h2A);
                mem[2] = er(0, 5, 7, 0, 'h2B);   mem[3] = er(0, 7, 7, 4, 0);
                mem[4] = er(6, 7, 2, 0, 'h21);   mem[5] = JR0;
            end
            6: begin
                mem[0] = ej(3, 5);               mem[1] = ei(9, 0, 2, 1);
                mem[2] = ei(9, 2, 2, 'h100);     mem[3] = JR0;
                mem[5] = ei(9, 2, 2, 'h20);      mem[6] = er(31, 0, 0, 0, 8);
            end
            7: begin
                mem[0] = ei('hD, 0, 5, 'hFFFF);  mem[1] = ei('hE, 5, 6, 'h8000);
                mem[2] = ei(5, 0, 0, 5);         mem[3] = ei('hC, 6, 2, 'hF0F0);
                mem[4] = JR0;
            end
            8: begin
                mem[0] = ei('hF, 0, 5, 'h8000);  mem[1] = ei('hD, 0, 6, 4);
                mem[2] = er(6, 5, 7, 0, 6);      mem[3] = er(6, 5, 8, 0, 7);
                mem[4] = er(8, 7, 9, 0, 'h23);   mem[5] = er(9, 7, 2, 0, 'h26);
                mem[6] = ei('h3F, 0, 2, 'h0F);   mem[7] = JR0;
            end
            9: begin
                mem[0] = ei(9, 0, 0, 7);         mem[1] = ei(9, 0, 2, 3);
                mem[2] = er(2, 0, 2, 0, 'h21);   mem[3] = JR0;
            end
            10: begin
                mem[0] = ej(2, 3);               mem[1] = ei(9, 0, 2, 2);
                mem[2] = ei(9, 2, 2, 'h40);      mem[3] = JR0;
            end
            11: begin
                mem[0] = ei('hF, 0, 8, 'hBFC0);  mem[1] = ei('hD, 8, 8, 'h0014);
                mem[2] = er(8, 0, 9, 0, 9);      mem[3] = ei('hB, 0, 2, 'hFFFF);
                mem[4] = JR0;                    mem[5] = ei(9, 2, 2, 'h10);
                mem[6] = er(9, 0, 0, 0, 8);
            end
            default: ;
        endcase
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        napplied++;
        if (act !== exp) begin
            nmiss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reset, load, release; count cycles with active=1 until halt
    task automatic run_prog(input int p, input int rw, input int ww,
                            output int cyc, output bit timeout);
        reset = 1'b1;
        load_prog(p);
        rd_wait = rw; wr_wait = ww;
        nwrites = 0; seen_read = 1'b0; viol = 0;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        cyc = 0; timeout = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (!active) begin timeout = 1'b0; break; end
            cyc++;
        end
    endtask

    typedef struct {
        int          prog;
        int          rdw;
        int          wrw;
        logic [31:0] v0;
        int          cyc;
        int          nw;
        logic [31:0] wa;
        logic [31:0] wd;
    } vec_t;

    vec_t vt[14];

    initial begin
        int cyc;
        bit to;

        vt[0]  = '{1,  0, 0, 32'h00000005,  9, 0, 32'h0, 32'h0};
        vt[1]  = '{2,  0, 0, 32'h00001234, 20, 1, 32'hBFC00100, 32'h00001234};
        vt[2]  = '{2,  3, 4, 32'h00001234, 45, 1, 32'hBFC00100, 32'h00001234};
        vt[3]  = '{3,  0, 0, 32'h00000001, 12, 0, 32'h0, 32'h0};
        vt[4]  = '{4,  0, 0, 32'hFFFFFFFE, 12, 0, 32'h0, 32'h0};
        vt[5]  = '{5,  0, 0, 32'h00000011, 21, 0, 32'h0, 32'h0};
        vt[6]  = '{6,  0, 0, 32'h00000121, 24, 0, 32'h0, 32'h0};
        vt[7]  = '{6,  3, 4, 32'h00000121, 48, 0, 32'h0, 32'h0};
        vt[8]  = '{7,  0, 0, 32'h000070F0, 18, 0, 32'h0, 32'h0};
        vt[9]  = '{8,  0, 0, 32'hF8000000, 27, 0, 32'h0, 32'h0};
        vt[10] = '{9,  0, 0, 32'h00000003, 15, 0, 32'h0, 32'h0};
        vt[11] = '{10, 0, 0, 32'h00000002, 12, 0, 32'h0, 32'h0};
        vt[12] = '{11, 0, 0, 32'h00000021, 27, 0, 32'h0, 32'h0};
        vt[13] = '{1,  1, 0, 32'h00000005, 12, 0, 32'h0, 32'h0};

        // Outputs held in reset
        load_prog(1);
        @(negedge clk); @(negedge clk);
        chk("rst_active",    32'(active),     32'd0);
        chk("rst_read",      32'(read),       32'd0);
        chk("rst_write",     32'(write),      32'd0);
        chk("rst_be",        32'(byteenable), 32'hF);
        chk("rst_address",   address,         32'hBFC00000);
        chk("rst_writedata", writedata,       32'd0);
        chk("rst_v0",        register_v0,     32'd0);

        // First rising edge after release: active and first fetch together
        reset = 1'b0;
        @(posedge clk); #1;
        chk("first_active", 32'(active), 32'd1);
        chk("first_read",   32'(read),   32'd1);
        chk("first_addr",   address,     32'hBFC00000);

        // Reset during a stalled fetch of the second instruction
        reset = 1'b1;
        load_prog(1);
        rd_wait = 0; wr_wait = 0;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        force_wait = 1'b1;
        repeat (3) @(negedge clk);
        chk("stall_read",  32'(read),   32'd1);
        chk("stall_addr",  address,     32'hBFC00004);
        chk("stall_v0",    register_v0, 32'h5);
        #2 reset = 1'b1;
        #1;
        chk("abort_read",   32'(read),   32'd0);
        chk("abort_active", 32'(active), 32'd0);
        chk("abort_addr",   address,     32'hBFC00000);
        chk("abort_v0",     register_v0, 32'd0);
        force_wait = 1'b0;
        run_prog(1, 0, 0, cyc, to);
        chk("restart_timeout", 32'(to), 32'd0);
        chk("restart_fetch",   first_raddr, 32'hBFC00000);
        chk("restart_v0",      register_v0, 32'h5);

        // Program table
        for (int i = 0; i < 14; i++) begin
            run_prog(vt[i].prog, vt[i].rdw, vt[i].wrw, cyc, to);
            chk($sformatf("v%0d_timeout", i), 32'(to), 32'd0);
            chk($sformatf("v%0d_v0", i), register_v0, vt[i].v0);
            chk($sformatf("v%0d_cycles", i), 32'(cyc), 32'(vt[i].cyc));
            chk($sformatf("v%0d_nwrites", i), 32'(nwrites), 32'(vt[i].nw));
            if (vt[i].nw > 0) begin
                chk($sformatf("v%0d_waddr", i), waddr, vt[i].wa);
                chk($sformatf("v%0d_wdata", i), wdata, vt[i].wd);
            end
            chk($sformatf("v%0d_first_fetch", i), first_raddr, 32'hBFC00000);
            repeat (3) @(negedge clk);
            chk($sformatf("v%0d_bus_idle", i), {30'd0, read, write}, 32'd0);
            chk($sformatf("v%0d_halted", i), 32'(active), 32'd0);
            chk($sformatf("v%0d_protocol", i), 32'(viol), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", napplied, nmiss);
        $finish;
    end

endmodule
